// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Load-use FSM states.
    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_e;

    // EX operand source selects.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding compare for one EX operand: the newest producer (EX/MEM) wins
// over the older one (MEM/WB); register 0 never forwards when hard-wired.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              rst,
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    output logic [1:0]        sel
);

    logic src_is_zero;

    // A hard-wired zero register is never a forwarding candidate.
    always_comb begin
        src_is_zero = (ZERO_REG != 0) && (src == '0);
    end

    // Select the youngest matching producer, register file otherwise.
    always_comb begin
        sel = FWD_RF;
        if (!rst && !src_is_zero) begin
            if (exmem_reg_write && (exmem_rd == src)) begin
                sel = FWD_MEM;
            end else if (memwb_reg_write && (memwb_rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, branch flush, memory-busy
// freeze, EX forwarding selects and a saturating stall-cycle counter.
// Control outputs are combinational from state and inputs.
// Priority each cycle: reset > mem_busy > branch_taken > load-use > normal.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_use_rs,
    input  logic              ifid_use_rt,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output state_e            dbg_state
);

    localparam int CW = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LAT - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             hit_rs, hit_rt, lu;

    // Load-use detection against the EX-stage load destination.
    always_comb begin
        hit_rs = (ifid_rs == idex_rd) && !((ZERO_REG != 0) && (ifid_rs == '0));
        hit_rt = (ifid_rt == idex_rd) && !((ZERO_REG != 0) && (ifid_rt == '0));
        lu     = idex_mem_read && ((ifid_use_rs && hit_rs) || (ifid_use_rt && hit_rt));
    end

    // Prioritised control outputs and FSM / counter next state.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall       = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            // Freeze: every stage holds, nothing advances.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (branch_taken) begin
            // Wrong-path instructions are discarded; any stall is abandoned.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
        end else if (state_q == LU_STALL) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cnt_d       = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
            end
        end else if (lu) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = LU_STALL;
                cnt_d   = CNT_INIT;
            end
        end
        if (stall && !mem_busy && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, remaining-stall count and stall statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign dbg_state = state_q;

    hazard_fwd_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .rst             (rst),
        .src             (idex_rs),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .sel             (fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .rst             (rst),
        .src             (idex_rt),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .sel             (fwd_b)
    );

endmodule
